// File: rtl/rom_cache.sv
// Direct-mapped read-only line cache for the flash window, sitting between
// memory_bus and sd_card; misses pull a whole line from sd_card byte by byte.
module rom_cache #(
   parameter int LINE_BITS  = 4,
   parameter int INDEX_BITS = 4
) (
   input  logic        clk_i,
   input  logic        reset_ni,
   input  logic        enable_i,
   input  logic [23:0] address_i,
   output logic [7:0]  data_out_o,
   output logic        busy_o,
   input  logic        invalidate_i,
   output logic        mem_req_o,
   output logic [23:0] mem_address_o,
   input  logic [7:0]  mem_data_i,
   input  logic        mem_valid_i,
   output logic [7:0]  fill_count_o
);
   localparam int TAG_BITS = 24 - LINE_BITS - INDEX_BITS;
   localparam int NLINES   = 1 << INDEX_BITS;
   localparam int RAM_AW   = LINE_BITS + INDEX_BITS;

   typedef enum logic [1:0] {IDLE, FILL, DONE} state_e;

   state_e                state_q, state_d;
   logic [NLINES-1:0]     valid_q, valid_d;
   logic [TAG_BITS-1:0]   tag_q [NLINES];
   logic [7:0]            ram_q [1 << RAM_AW];
   logic [7:0]            data_q;
   logic [23:0]           addr_q;
   logic                  mem_req_q, mem_req_d;
   logic [23:0]           mem_addr_q, mem_addr_d;
   logic [INDEX_BITS-1:0] fidx_q, fidx_d;
   logic [TAG_BITS-1:0]   ftag_q, ftag_d;
   logic [LINE_BITS-1:0]  cnt_q, cnt_d;
   logic                  pend_q, pend_d;
   logic [7:0]            fills_q, fills_d;
   logic                  tag_we, ram_we;

   logic [INDEX_BITS-1:0] idx;
   logic [TAG_BITS-1:0]   tag;
   logic                  hit;

   assign idx = address_i[LINE_BITS +: INDEX_BITS];
   assign tag = address_i[RAM_AW +: TAG_BITS];
   assign hit = valid_q[idx] && (tag_q[idx] == tag);

   // A hit still stalls one cycle whenever the RAM read has not caught up with address.
   assign busy_o        = reset_ni && enable_i &&
                          (state_q != IDLE || !hit || address_i != addr_q);
   assign data_out_o    = data_q;
   assign mem_req_o     = mem_req_q;
   assign mem_address_o = mem_addr_q;
   assign fill_count_o  = fills_q;

   always_comb begin
      state_d    = state_q;
      valid_d    = valid_q;
      mem_req_d  = mem_req_q;
      mem_addr_d = mem_addr_q;
      fidx_d     = fidx_q;
      ftag_d     = ftag_q;
      cnt_d      = cnt_q;
      pend_d     = pend_q;
      fills_d    = fills_q;
      tag_we     = 1'b0;
      ram_we     = 1'b0;
      if (invalidate_i) valid_d = '0;
      case (state_q)
         IDLE: begin
            if (enable_i && !hit) begin
               fidx_d     = idx;
               ftag_d     = tag;
               mem_addr_d = {tag, idx, {LINE_BITS{1'b0}}};
               mem_req_d  = 1'b1;
               cnt_d      = '0;
               state_d    = FILL;
            end
         end
         FILL: begin
            if (invalidate_i) pend_d = 1'b1;
            if (mem_valid_i) begin
               ram_we = 1'b1;
               cnt_d  = cnt_q + 1'b1;
               if (cnt_q == {LINE_BITS{1'b1}}) begin
                  mem_req_d = 1'b0;
                  tag_we    = 1'b1;
                  // A line whose fill overlapped an invalidate predates the new image.
                  if (!(pend_q || invalidate_i)) valid_d[fidx_q] = 1'b1;
                  fills_d   = fills_q + 8'd1;
                  state_d   = DONE;
               end
            end
         end
         DONE: begin
            pend_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!reset_ni) begin
         state_q    <= IDLE;
         valid_q    <= '0;
         mem_req_q  <= 1'b0;
         mem_addr_q <= '0;
         fidx_q     <= '0;
         ftag_q     <= '0;
         cnt_q      <= '0;
         pend_q     <= 1'b0;
         fills_q    <= '0;
         data_q     <= '0;
         addr_q     <= '0;
      end else begin
         state_q    <= state_d;
         valid_q    <= valid_d;
         mem_req_q  <= mem_req_d;
         mem_addr_q <= mem_addr_d;
         fidx_q     <= fidx_d;
         ftag_q     <= ftag_d;
         cnt_q      <= cnt_d;
         pend_q     <= pend_d;
         fills_q    <= fills_d;
         data_q     <= ram_q[address_i[RAM_AW-1:0]];
         addr_q     <= address_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (tag_we) tag_q[fidx_q] <= ftag_q;
      if (ram_we) ram_q[{fidx_q, cnt_q}] <= mem_data_i;
   end
endmodule

// File: tb/tb_rom_cache.sv
// Directed bench for rom_cache: fills, hits, conflicts, invalidate and reset.
module tb_rom_cache;
   logic        clk_i = 1'b0;
   logic        reset_ni;
   logic        enable_i;
   logic [23:0] address_i;
   logic [7:0]  data_out_o;
   logic        busy_o;
   logic        invalidate_i;
   logic        mem_req_o;
   logic [23:0] mem_address_o;
   logic [7:0]  mem_data_i;
   logic        mem_valid_i;
   logic [7:0]  fill_count_o;

   int tests = 0;
   int fails = 0;
   int gaps [16] = '{1, 3, 2, 5, 1, 4, 2, 1, 3, 5, 2, 1, 4, 3, 1, 2};

   rom_cache dut (
      .clk_i(clk_i), .reset_ni(reset_ni), .enable_i(enable_i), .address_i(address_i),
      .data_out_o(data_out_o), .busy_o(busy_o), .invalidate_i(invalidate_i),
      .mem_req_o(mem_req_o), .mem_address_o(mem_address_o), .mem_data_i(mem_data_i),
      .mem_valid_i(mem_valid_i), .fill_count_o(fill_count_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk(input string name, input logic [23:0] obs, input logic [23:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %0h expected %0h", name, obs, exp);
      end
   endtask

   // sd_card model: 16 bytes first..first+15, optional gaps, optional
   // invalidate on one byte and enable drop before one byte.
   task automatic stream(input logic [7:0] first, input bit gapped,
                         input int inval_at, input int drop_at);
      for (int i = 0; i < 16; i++) begin
         if (i == drop_at) enable_i = 1'b0;
         if (gapped) repeat (gaps[i]) tick();
         mem_valid_i  = 1'b1;
         mem_data_i   = first + 8'(i);
         invalidate_i = (i == inval_at);
         #1;
         if (i == 15) chk("mem_req_before_last", 24'(mem_req_o), 24'd1);
         tick();
         mem_valid_i  = 1'b0;
         invalidate_i = 1'b0;
      end
   endtask

   initial begin
      reset_ni = 1'b0; enable_i = 1'b1; address_i = 24'h00C005;
      invalidate_i = 1'b0; mem_data_i = 8'h00; mem_valid_i = 1'b0;
      tick(); tick();
      chk("rst_busy", 24'(busy_o), 24'd0);
      chk("rst_mem_req", 24'(mem_req_o), 24'd0);
      chk("rst_mem_addr", mem_address_o, 24'h000000);
      chk("rst_data", 24'(data_out_o), 24'h00);
      chk("rst_fills", 24'(fill_count_o), 24'd0);
      reset_ni = 1'b1; enable_i = 1'b0;
      tick();

      // cold read
      enable_i = 1'b1; address_i = 24'h00C005; #1;
      chk("cold_busy", 24'(busy_o), 24'd1);
      tick();
      chk("cold_req", 24'(mem_req_o), 24'd1);
      chk("cold_maddr", mem_address_o, 24'h00C000);
      stream(8'h10, 1'b0, -1, -1);
      chk("cold_req_drop", 24'(mem_req_o), 24'd0);
      chk("cold_busy_done", 24'(busy_o), 24'd1);
      chk("cold_fills", 24'(fill_count_o), 24'd1);
      tick();
      chk("cold_busy_end", 24'(busy_o), 24'd0);
      chk("cold_data", 24'(data_out_o), 24'h15);

      // hit in the same line
      address_i = 24'h00C00A; #1;
      chk("hit_busy1", 24'(busy_o), 24'd1);
      tick();
      chk("hit_busy0", 24'(busy_o), 24'd0);
      chk("hit_data", 24'(data_out_o), 24'h1A);
      chk("hit_noreq", 24'(mem_req_o), 24'd0);

      // conflict at index 0
      address_i = 24'h01C005; #1;
      chk("conf_busy", 24'(busy_o), 24'd1);
      tick();
      chk("conf_req", 24'(mem_req_o), 24'd1);
      chk("conf_maddr", mem_address_o, 24'h01C000);
      stream(8'h40, 1'b0, -1, -1);
      tick();
      chk("conf_data", 24'(data_out_o), 24'h45);
      chk("conf_fills", 24'(fill_count_o), 24'd2);
      address_i = 24'h00C005; #1;
      chk("back_busy", 24'(busy_o), 24'd1);
      tick();
      chk("back_maddr", mem_address_o, 24'h00C000);
      stream(8'h10, 1'b0, -1, -1);
      tick();
      chk("back_data", 24'(data_out_o), 24'h15);
      chk("back_fills", 24'(fill_count_o), 24'd3);

      // invalidate with the line cached
      enable_i = 1'b0; invalidate_i = 1'b1;
      tick();
      invalidate_i = 1'b0; enable_i = 1'b1; address_i = 24'h00C000; #1;
      chk("inv_busy", 24'(busy_o), 24'd1);
      tick();
      chk("inv_req", 24'(mem_req_o), 24'd1);

      // invalidate on byte 7 of the fill
      stream(8'h20, 1'b0, 7, -1);
      chk("invf_req_drop", 24'(mem_req_o), 24'd0);
      chk("invf_fills", 24'(fill_count_o), 24'd4);
      tick();
      chk("invf_remiss_busy", 24'(busy_o), 24'd1);
      tick();
      chk("invf_remiss_req", 24'(mem_req_o), 24'd1);
      chk("invf_remiss_maddr", mem_address_o, 24'h00C000);

      // enable dropped mid-fill, irregular byte gaps
      stream(8'h30, 1'b1, -1, 3);
      chk("gap_busy", 24'(busy_o), 24'd0);
      chk("gap_fills", 24'(fill_count_o), 24'd5);
      tick();
      enable_i = 1'b1; address_i = 24'h00C000; #1;
      chk("gap_hit_busy", 24'(busy_o), 24'd0);
      chk("gap_b0", 24'(data_out_o), 24'h30);
      address_i = 24'h00C00F; #1;
      chk("gap_busyF", 24'(busy_o), 24'd1);
      tick();
      chk("gap_bF", 24'(data_out_o), 24'h3F);
      address_i = 24'h00C007;
      tick();
      chk("gap_b7", 24'(data_out_o), 24'h37);
      chk("gap_noreq", 24'(mem_req_o), 24'd0);

      // reset in the middle of a fill
      address_i = 24'h123456;
      tick();
      chk("rf_req", 24'(mem_req_o), 24'd1);
      chk("rf_maddr", mem_address_o, 24'h123450);
      for (int i = 0; i < 5; i++) begin
         mem_valid_i = 1'b1; mem_data_i = 8'hA0 + 8'(i);
         tick();
      end
      mem_valid_i = 1'b0;
      reset_ni = 1'b0;
      tick();
      chk("rf_rst_req", 24'(mem_req_o), 24'd0);
      chk("rf_rst_data", 24'(data_out_o), 24'h00);
      chk("rf_rst_fills", 24'(fill_count_o), 24'd0);
      chk("rf_rst_busy", 24'(busy_o), 24'd0);
      reset_ni = 1'b1; address_i = 24'h00C00F; #1;
      chk("rf_miss_busy", 24'(busy_o), 24'd1);
      tick();
      chk("rf_miss_req", 24'(mem_req_o), 24'd1);
      chk("rf_miss_maddr", mem_address_o, 24'h00C000);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
